// File: rtl/nvdla_sdp_rdma_group_ctrl_pkg.sv
// Shared SDP RDMA definitions: group status encoding, group-control FSM states
// and the status decode used to drive the register-block read-back fields.
package nvdla_sdp_rdma_group_ctrl_pkg;

  localparam int unsigned GRP_NUM  = 2;
  localparam int unsigned STATUS_W = 2;

  localparam logic [STATUS_W-1:0] STATUS_IDLE    = 2'd0;
  localparam logic [STATUS_W-1:0] STATUS_RUNNING = 2'd1;
  localparam logic [STATUS_W-1:0] STATUS_PENDING = 2'd2;

  typedef enum logic [1:0] {
    RDMA_IDLE = 2'd0,
    RDMA_LOAD = 2'd1,
    RDMA_RUN  = 2'd2
  } rdma_state_e;

  // Running wins over pending so the active group never reads back as PENDING.
  function automatic logic [STATUS_W-1:0] group_status(
    input logic               grp,
    input rdma_state_e        st,
    input logic               cons,
    input logic [GRP_NUM-1:0] pend
  );
    logic [STATUS_W-1:0] s;
    s = STATUS_IDLE;
    if ((grp == cons) && (st != RDMA_IDLE)) begin
      s = STATUS_RUNNING;
    end else if (pend[grp]) begin
      s = STATUS_PENDING;
    end
    return s;
  endfunction

endpackage

// File: rtl/nvdla_sdp_rdma_group_ctrl.sv
// Ping-pong register-group controller for SDP RDMA: tracks per-group pending
// operations, sequences load/run of the consumer group and reports status.
module nvdla_sdp_rdma_group_ctrl
  import nvdla_sdp_rdma_group_ctrl_pkg::*;
(
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rst,
  input  logic                producer,
  input  logic                op_en_trigger,
  input  logic                op_done,
  output logic                consumer,
  output logic [STATUS_W-1:0] status_0,
  output logic [STATUS_W-1:0] status_1,
  output logic                op_load,
  output logic                op_en,
  output logic [GRP_NUM-1:0]  intr_done,
  output logic                trig_err
);

  rdma_state_e          state;
  rdma_state_e          state_nxt;
  logic [GRP_NUM-1:0]   pending;
  logic [GRP_NUM-1:0]   pending_nxt;
  logic                 consumer_nxt;
  logic [GRP_NUM-1:0]   intr_done_nxt;
  logic                 trig_err_nxt;
  logic                 op_load_nxt;
  logic                 op_en_nxt;
  logic [STATUS_W-1:0]  status_0_nxt;
  logic [STATUS_W-1:0]  status_1_nxt;
  logic                 trig_busy;
  logic                 trig_ok;

  // State register
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state <= RDMA_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, pending bookkeeping and next values of every registered output
  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending;
    consumer_nxt  = consumer;
    intr_done_nxt = '0;
    trig_err_nxt  = 1'b0;

    trig_busy = (state != RDMA_IDLE) && (producer == consumer);
    trig_ok   = op_en_trigger && !pending[producer] && !trig_busy;

    case (state)
      RDMA_IDLE: begin
        if (pending[consumer]) begin
          state_nxt = RDMA_LOAD;
        end
      end
      RDMA_LOAD: begin
        state_nxt = RDMA_RUN;
      end
      RDMA_RUN: begin
        if (op_done) begin
          state_nxt               = RDMA_IDLE;
          pending_nxt[consumer]   = 1'b0;
          intr_done_nxt[consumer] = 1'b1;
          consumer_nxt            = ~consumer;
        end
      end
      default: begin
        state_nxt = RDMA_IDLE;
      end
    endcase

    // A legal trigger never targets the group being retired, so the bits are disjoint
    if (trig_ok) begin
      pending_nxt[producer] = 1'b1;
    end
    trig_err_nxt = op_en_trigger && !trig_ok;

    op_load_nxt  = (state_nxt == RDMA_LOAD);
    op_en_nxt    = (state_nxt == RDMA_RUN);
    status_0_nxt = group_status(1'b0, state_nxt, consumer_nxt, pending_nxt);
    status_1_nxt = group_status(1'b1, state_nxt, consumer_nxt, pending_nxt);
  end

  // Bookkeeping and output registers
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      pending   <= '0;
      consumer  <= 1'b0;
      intr_done <= '0;
      trig_err  <= 1'b0;
      op_load   <= 1'b0;
      op_en     <= 1'b0;
      status_0  <= STATUS_IDLE;
      status_1  <= STATUS_IDLE;
    end else begin
      pending   <= pending_nxt;
      consumer  <= consumer_nxt;
      intr_done <= intr_done_nxt;
      trig_err  <= trig_err_nxt;
      op_load   <= op_load_nxt;
      op_en     <= op_en_nxt;
      status_0  <= status_0_nxt;
      status_1  <= status_1_nxt;
    end
  end

endmodule

// File: tb/tb_nvdla_sdp_rdma_group_ctrl.sv
// Self-checking bench for the SDP RDMA group controller: directed scenarios plus
// random traffic, all compared against a job-age reference model.
module tb_nvdla_sdp_rdma_group_ctrl;

  logic       nvdla_core_clk;
  logic       nvdla_core_rst;
  logic       producer;
  logic       op_en_trigger;
  logic       op_done;
  logic       consumer;
  logic [1:0] status_0;
  logic [1:0] status_1;
  logic       op_load;
  logic       op_en;
  logic [1:0] intr_done;
  logic       trig_err;
  logic [10:0] dut_vec;

  int tests_run;
  int tests_failed;

  // Reference model: job age -1 = no job, 0 = load cycle, 1 = running
  int         m_age;
  logic       m_cons;
  logic [1:0] m_pend;
  logic [1:0] m_intr;
  logic       m_err;

  nvdla_sdp_rdma_group_ctrl dut (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .producer       (producer),
    .op_en_trigger  (op_en_trigger),
    .op_done        (op_done),
    .consumer       (consumer),
    .status_0       (status_0),
    .status_1       (status_1),
    .op_load        (op_load),
    .op_en          (op_en),
    .intr_done      (intr_done),
    .trig_err       (trig_err)
  );

  assign dut_vec = {consumer, status_1, status_0, op_load, op_en, intr_done, trig_err};

  initial nvdla_core_clk = 1'b0;
  always #5 nvdla_core_clk = ~nvdla_core_clk;

  function automatic logic [1:0] m_stat(input int g);
    if ((g == int'(m_cons)) && (m_age >= 0)) return 2'd1;
    if (m_pend[g]) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [10:0] model_vec();
    return {m_cons, m_stat(1), m_stat(0), (m_age == 0), (m_age >= 1), m_intr, m_err};
  endfunction

  task automatic model_step(input logic r, input logic t, input logic p, input logic d);
    int         old_age;
    logic       old_cons;
    logic [1:0] old_pend;
    logic       bad;
    if (r) begin
      m_age = -1; m_cons = 1'b0; m_pend = 2'b00; m_intr = 2'b00; m_err = 1'b0;
    end else begin
      old_age  = m_age;
      old_cons = m_cons;
      old_pend = m_pend;
      bad      = old_pend[p] || ((old_age >= 0) && (p == old_cons));
      m_err    = t && bad;
      m_intr   = 2'b00;
      if ((old_age >= 1) && d) begin
        m_pend[old_cons] = 1'b0;
        m_intr[old_cons] = 1'b1;
        m_cons           = ~old_cons;
        m_age            = -1;
      end else if (old_age >= 0) begin
        m_age = 1;
      end else if (old_pend[old_cons]) begin
        m_age = 0;
      end
      if (t && !bad) m_pend[p] = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit
  task automatic tick(input logic r, input logic t, input logic p, input logic d);
    nvdla_core_rst = r;
    op_en_trigger  = t;
    producer       = p;
    op_done        = d;
    @(posedge nvdla_core_clk);
    model_step(r, t, p, d);
    #1;
    nvdla_core_rst = 1'b0;
    op_en_trigger  = 1'b0;
    op_done        = 1'b0;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    tests_run++;
    if (dut_vec !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected %b", dut_vec, 11'd0);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (dut_vec !== model_vec()) begin
      tests_failed++;
      $display("FAIL reset_idle: got %b expected %b", dut_vec, model_vec());
    end
  endtask

  task automatic test_basic();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (status_0 !== 2'd2 || op_load !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_pending: status_0=%0d op_load=%b expected 2/0", status_0, op_load);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (op_load !== 1'b1 || op_en !== 1'b0 || status_0 !== 2'd1) begin
      tests_failed++;
      $display("FAIL basic_load: op_load=%b op_en=%b status_0=%0d expected 1/0/1", op_load, op_en, status_0);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (op_en !== 1'b1 || op_load !== 1'b0 || status_0 !== 2'd1 || dut_vec !== model_vec()) begin
        tests_failed++;
        $display("FAIL basic_run[%0d]: got %b expected %b", i, dut_vec, model_vec());
      end
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (intr_done !== 2'b01 || consumer !== 1'b1 || status_0 !== 2'd0 || op_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done: intr=%b cons=%b status_0=%0d op_en=%b expected 01/1/0/0",
               intr_done, consumer, status_0, op_en);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (dut_vec !== model_vec() || intr_done !== 2'b00) begin
      tests_failed++;
      $display("FAIL basic_after: got %b expected %b", dut_vec, model_vec());
    end
  endtask

  task automatic test_ping_pong();
    int intr_seen [$];
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tests_run++;
    if (status_1 !== 2'd2 || status_0 !== 2'd1 || trig_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL pp_both_queued: status_1=%0d status_0=%0d err=%b expected 2/1/0", status_1, status_0, trig_err);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    if (intr_done != 2'b00) intr_seen.push_back(int'(intr_done));
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (op_load !== 1'b1 || consumer !== 1'b1 || status_1 !== 2'd1) begin
      tests_failed++;
      $display("FAIL pp_load_g1: op_load=%b cons=%b status_1=%0d expected 1/1/1", op_load, consumer, status_1);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    if (intr_done != 2'b00) intr_seen.push_back(int'(intr_done));
    tests_run++;
    if (intr_seen.size() != 2 || intr_seen[0] != 1 || intr_seen[1] != 2 || consumer !== 1'b0) begin
      tests_failed++;
      $display("FAIL pp_intr_order: count=%0d cons=%b expected 2 pulses 01,10 cons 0", intr_seen.size(), consumer);
    end
  endtask

  task automatic test_illegal();
    int n_err, n_load, n_intr;
    n_err = 0; n_load = 0; n_intr = 0;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, (i < 2), 1'b0, (i == 4));
      n_err  += int'(trig_err);
      n_load += int'(op_load);
      n_intr += int'(intr_done[0]) + int'(intr_done[1]);
      tests_run++;
      if (dut_vec !== model_vec()) begin
        tests_failed++;
        $display("FAIL illegal_step[%0d]: got %b expected %b", i, dut_vec, model_vec());
      end
    end
    tests_run++;
    if (n_err != 1 || n_load != 1 || n_intr != 1) begin
      tests_failed++;
      $display("FAIL illegal_counts: err=%0d load=%0d intr=%0d expected 1/1/1", n_err, n_load, n_intr);
    end
  endtask

  task automatic test_out_of_order();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      tests_run++;
      if (op_load !== 1'b0 || op_en !== 1'b0 || status_1 !== 2'd2 || consumer !== 1'b0) begin
        tests_failed++;
        $display("FAIL ooo_wait[%0d]: got %b expected load=0 en=0 status_1=2 cons=0", i, dut_vec);
      end
    end
  endtask

  task automatic test_simultaneous();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    tests_run++;
    if (consumer !== 1'b1 || trig_err !== 1'b0 || intr_done !== 2'b01 || status_1 !== 2'd2) begin
      tests_failed++;
      $display("FAIL simul_edge: got %b expected cons=1 err=0 intr=01 status_1=2", dut_vec);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (op_load !== 1'b1 || status_1 !== 2'd1 || dut_vec !== model_vec()) begin
      tests_failed++;
      $display("FAIL simul_load: got %b expected %b", dut_vec, model_vec());
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    tests_run++;
    if (trig_err !== 1'b1 || intr_done !== 2'b10 || status_1 !== 2'd0) begin
      tests_failed++;
      $display("FAIL simul_same_grp: got %b expected err=1 intr=10 status_1=0", dut_vec);
    end
  endtask

  task automatic test_reset_in_run();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (dut_vec !== 11'd0) begin
      tests_failed++;
      $display("FAIL rst_run_abort: got %b expected %b", dut_vec, 11'd0);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (dut_vec !== 11'd0) begin
      tests_failed++;
      $display("FAIL rst_run_quiet: got %b expected %b", dut_vec, 11'd0);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (op_load !== 1'b1 || consumer !== 1'b0 || status_0 !== 2'd1) begin
      tests_failed++;
      $display("FAIL rst_run_restart: got %b expected load=1 cons=0 status_0=1", dut_vec);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
      tests_run++;
      if (dut_vec !== model_vec() || status_0 === 2'd3 || status_1 === 2'd3) begin
        tests_failed++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: got %b expected %b", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    nvdla_core_rst = 1'b1;
    producer       = 1'b0;
    op_en_trigger  = 1'b0;
    op_done        = 1'b0;
    m_age = -1; m_cons = 1'b0; m_pend = 2'b00; m_intr = 2'b00; m_err = 1'b0;
    test_reset();
    test_basic();
    test_ping_pong();
    test_illegal();
    test_out_of_order();
    test_simultaneous();
    test_reset_in_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/nvdla_sdp_rdma_group_ctrl.md
NVDLA_SDP_RDMA_GROUP_CTRL -- requirements
Module: nvdla_sdp_rdma_group_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 Ports SHALL be:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rst  in  1  synchronous active-high reset.
- producer  in  1  group currently selected by software for programming.
- op_en_trigger  in  1  single-cycle software write of op_en=1; targets group = producer in the same cycle.
- op_done  in  1  single-cycle pulse from the RDMA datapath: current operation finished.
- consumer  out  1  group the hardware executes or will execute next.
- status_0  out  2  status of group 0.
- status_1  out  2  status of group 1.
- op_load  out  1  single-cycle pulse: datapath latches group = consumer configuration.
- op_en  out  1  level: datapath operation active.
- intr_done  out  2  one-hot single-cycle completion pulse, bit g = group g.
- trig_err  out  1  single-cycle pulse: illegal trigger was ignored.
REQ-003 consumer, status_0 and status_1 SHALL connect directly to the like-named read-only inputs of the RDMA single-register block.

Function
REQ-010 SHALL keep one pending flag per group; op_en_trigger sets pending[producer] at the next edge.
REQ-011 Status encoding SHALL be 0=IDLE, 1=RUNNING, 2=PENDING; 3 SHALL never be output.
REQ-012 status_g SHALL be RUNNING when g==consumer and state is LOAD or RUN; else PENDING when pending[g]; else IDLE.
REQ-013 FSM states SHALL be IDLE, LOAD and RUN.
- IDLE->LOAD when pending[consumer]==1.
- LOAD->RUN unconditionally after one cycle.
- RUN->IDLE on op_done.
REQ-014 op_load SHALL be 1 exactly in the LOAD cycle; op_en SHALL be 1 exactly while in RUN.
REQ-015 On op_done in RUN:
- clear pending[consumer];
- pulse intr_done[consumer] in the following cycle;
- toggle consumer at the same edge as the RUN->IDLE transition.
REQ-016 Latency: trigger in cycle N with the FSM idle on that group SHALL give pending in N+1, op_load in N+2 and op_en from N+3.
REQ-017 A trigger targeting a group already pending, or currently LOAD/RUN, SHALL be ignored and pulse trig_err in the next cycle; state and pending are unchanged.
REQ-018 op_done outside RUN SHALL be ignored, with no state, consumer or intr change.
REQ-019 Simultaneous op_done and a trigger for the other group SHALL both take effect.
- Example: consumer=0 in RUN, trigger producer=1 -> pending[1]=1 and consumer=1 at the same edge -> IDLE, then LOAD next cycle.
REQ-020 Simultaneous op_done and a trigger for the running group SHALL be treated as illegal per REQ-017.
REQ-021 Both groups pending SHALL execute strictly in consumer order, alternating 0,1,0,...
- There is no skip when only the non-consumer group is pending: IDLE waits for pending[consumer].

Reset
REQ-030 While nvdla_core_rst is high at an edge:
- state=IDLE, consumer=0, pending=2'b00;
- op_load=0, op_en=0, intr_done=0, trig_err=0;
- status_0=status_1=0.
REQ-031 Reset asserted mid-operation (LOAD/RUN) SHALL abort without an intr_done pulse; an op_done in the reset cycle is discarded.

Structure
REQ-040 A shared SDP package SHALL hold the status encoding constants (IDLE/RUNNING/PENDING) and the FSM state enum.
REQ-041 No sub-module is needed; all logic is one flat block. Expected size is about 150 RTL lines.

Verification
REQ-050 Basic: reset, trigger with producer=0 -> pending at N+1 (status_0=2), op_load at N+2, op_en at N+3 (status_0=1); op_done -> intr_done=01, consumer=1, status_0=0.
REQ-051 Ping-pong: trigger groups 0 then 1 back-to-back -> status_1=2 while group 0 runs; after op_done, group 1 is loaded within 2 cycles; intr_done 01 then 10.
REQ-052 Illegal: trigger producer=0 twice while group 0 is pending -> one trig_err pulse, single execution, one intr_done.
REQ-053 Out-of-order: consumer=0 with only group 1 pending -> FSM stays IDLE, op_load never asserts, status_1=2.
REQ-054 Simultaneous: op_done together with a trigger for group 1 during a group 0 run -> consumer=1, op_load 1 cycle later, no trig_err.
REQ-055 Reset in RUN -> next cycle all outputs 0, no intr_done; a following trigger restarts at group 0.
